int_ctrl: RTL and testbench

Interrupt priority controller for the three-line interrupt path in the memory-stage CSR block. Takes the pending bits from the interrupt request register, selects the highest-priority unmasked line that may preempt the current handler, and handshakes an interrupt entry with the pipeline. Tracks nested handlers in an in-service register and issues the clear strobe back to the request register once entry is accepted.

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/int_ctrl_prio_enc3.sv | 11 +
 rtl/int_ctrl.sv | 92 +++++++++
 tb/tb_int_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared definitions for the interrupt priority controller
package int_ctrl_pkg;
  localparam int NUM_IRQ = 3;
  localparam int ID_W    = 2;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_3000;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_CLR  = 2'b10
  } state_t;

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return {{(NUM_IRQ-1){1'b0}}, 1'b1} << id;
  endfunction
endpackage

// File: rtl/int_ctrl_prio_enc3.sv
// rtl/int_ctrl_prio_enc3.sv - 3-bit highest-set-bit encoder
module prio_enc3 (
  input  logic [2:0] bits,
  output logic       valid,
  output logic [1:0] idx
);
  always_comb begin
    valid = |bits;
    idx   = bits[2] ? 2'd2 : (bits[1] ? 2'd1 : 2'd0);
  end
endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt priority controller with nesting and request clear strobe
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   IR,
  input  logic                 ie,
  input  logic [NUM_IRQ-1:0]   mask,
  input  logic                 int_ack,
  input  logic                 eret,
  output logic                 int_req,
  output logic [ID_W-1:0]      int_id,
  output logic [31:0]          int_vec,
  output logic                 Clr,
  output logic [NUM_IRQ-1:0]   ClrInt,
  output logic [NUM_IRQ-1:0]   ISR
);
  state_t               state, state_nx;
  logic                 isr_valid, cand_any, cand_valid;
  logic [ID_W-1:0]      cur_prio, cand_id, id_nx;
  logic [NUM_IRQ-1:0]   above, eligible, isr_nx, clrint_nx;
  logic                 req_nx, clr_nx;

  prio_enc3 u_cur (.bits(ISR), .valid(isr_valid), .idx(cur_prio));

  // Only lines strictly above the active handler may preempt it.
  always_comb begin
    above = '1;
    if (isr_valid) begin
      case (cur_prio)
        2'd0:    above = 3'b110;
        2'd1:    above = 3'b100;
        default: above = 3'b000;
      endcase
    end
  end

  assign eligible = IR & mask & ~ISR & above;

  prio_enc3 u_cand (.bits(eligible), .valid(cand_any), .idx(cand_id));

  assign cand_valid = ie & cand_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      int_id  <= '0;
      ISR     <= '0;
      int_req <= 1'b0;
      Clr     <= 1'b0;
      ClrInt  <= '0;
    end else begin
      state   <= state_nx;
      int_id  <= id_nx;
      ISR     <= isr_nx;
      int_req <= req_nx;
      Clr     <= clr_nx;
      ClrInt  <= clrint_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cand_valid) state_nx = ST_REQ;
      ST_REQ: begin
        if (int_ack)  state_nx = ST_CLR;
        else if (!ie) state_nx = ST_IDLE;
      end
      ST_CLR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // eret retires the top handler while an ack may open a higher one on the same edge.
  always_comb begin
    id_nx = int_id;
    if (state == ST_IDLE && cand_valid) id_nx = cand_id;
    isr_nx = ISR;
    if (eret && isr_valid) isr_nx = isr_nx & ~id_onehot(cur_prio);
    if (state == ST_REQ && int_ack) isr_nx = isr_nx | id_onehot(int_id);
    req_nx    = (state_nx == ST_REQ);
    clr_nx    = (state_nx == ST_CLR);
    clrint_nx = clr_nx ? id_onehot(id_nx) : '0;
  end

  assign int_vec = VEC_BASE + ({30'd0, int_id} * VEC_STRIDE);
endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl with a reference model
module tb_int_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  IR = 3'b000;
  logic        ie = 1'b1;
  logic [2:0]  mask = 3'b111;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vec;
  logic        Clr;
  logic [2:0]  ClrInt;
  logic [2:0]  ISR;

  int checks = 0;
  int errors = 0;

  logic       m_req, m_clr;
  logic [1:0] m_id;
  logic [2:0] m_isr, m_clrint;

  int_ctrl dut (
    .clk(clk), .rst(rst), .IR(IR), .ie(ie), .mask(mask), .int_ack(int_ack),
    .eret(eret), .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
    .Clr(Clr), .ClrInt(ClrInt), .ISR(ISR)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model and the request-register stand-in see the pre-edge inputs.
  task automatic tick();
    logic       n_req, n_clr;
    logic [1:0] n_id;
    logic [2:0] n_isr, n_clrint, ir_nx;
    int         top, cand;
    top = -1;
    for (int i = 0; i < 3; i++) if (m_isr[i]) top = i;
    cand = -1;
    for (int i = 0; i < 3; i++)
      if (ie && IR[i] && mask[i] && !m_isr[i] && i > top) cand = i;
    n_isr = m_isr; n_id = m_id; n_req = 1'b0; n_clr = 1'b0;
    if (eret && top >= 0) n_isr[top] = 1'b0;
    if (m_req) begin
      if (int_ack) begin n_isr[m_id] = 1'b1; n_clr = 1'b1; end
      else n_req = ie;
    end else if (!m_clr && cand >= 0) begin
      n_req = 1'b1; n_id = cand[1:0];
    end
    n_clrint = n_clr ? (3'b001 << m_id) : 3'b000;
    ir_nx = Clr ? (IR & ~ClrInt) : IR;
    @(posedge clk); #1;
    if (!rst) begin
      m_req = 0; m_clr = 0; m_id = 0; m_isr = 0; m_clrint = 0;
    end else begin
      m_req = n_req; m_clr = n_clr; m_id = n_id; m_isr = n_isr; m_clrint = n_clrint;
    end
    IR = ir_nx;
  endtask

  task automatic do_reset();
    rst = 1'b0; IR = 0; int_ack = 0; eret = 0; ie = 1; mask = 3'b111;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    IR = 3'b111; #2; rst = 1'b0; #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", int_req); end
    checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", int_id); end
    checks++; if (int_vec !== 32'h3000) begin errors++; $display("FAIL reset_vec got=%h exp=3000", int_vec); end
    checks++; if ({Clr, ClrInt, ISR} !== 7'd0) begin errors++; $display("FAIL reset_clr_isr got=%b exp=0", {Clr, ClrInt, ISR}); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    IR = 3'b001; tick();
    checks++; if ({int_req, int_id} !== 3'b1_00) begin errors++; $display("FAIL single_req got=%b exp=100", {int_req, int_id}); end
    checks++; if (int_vec !== 32'h3000) begin errors++; $display("FAIL single_vec got=%h exp=3000", int_vec); end
    int_ack = 1; tick(); int_ack = 0;
    checks++; if ({int_req, Clr, ClrInt, ISR} !== 8'b0_1_001_001) begin errors++; $display("FAIL single_ack got=%b exp=01001001", {int_req, Clr, ClrInt, ISR}); end
    tick();
    checks++; if ({Clr, ClrInt} !== 4'b0) begin errors++; $display("FAIL single_clr_once got=%b exp=0000", {Clr, ClrInt}); end
  endtask

  task automatic test_priority();
    do_reset();
    IR = 3'b011; tick();
    checks++; if ({int_req, int_id} !== 3'b1_01 || int_vec !== 32'h3010) begin errors++; $display("FAIL prio_req got=%b/%h exp=101/3010", {int_req, int_id}, int_vec); end
    int_ack = 1; tick(); int_ack = 0;
    checks++; if ({ClrInt, ISR} !== 6'b010_010) begin errors++; $display("FAIL prio_clr got=%b exp=010010", {ClrInt, ISR}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL prio_no_low got=%b exp=0", int_req); end
    end
  endtask

  task automatic test_nesting();
    do_reset();
    IR = 3'b001; tick(); int_ack = 1; tick(); int_ack = 0; tick();
    IR = IR | 3'b100; tick();
    checks++; if ({int_req, int_id} !== 3'b1_10 || int_vec !== 32'h3020) begin errors++; $display("FAIL nest_req got=%b/%h exp=110/3020", {int_req, int_id}, int_vec); end
    int_ack = 1; tick(); int_ack = 0;
    checks++; if (ISR !== 3'b101) begin errors++; $display("FAIL nest_isr got=%b exp=101", ISR); end
    tick(); eret = 1; tick(); eret = 0;
    checks++; if (ISR !== 3'b001) begin errors++; $display("FAIL nest_eret1 got=%b exp=001", ISR); end
    eret = 1; tick(); eret = 0;
    checks++; if (ISR !== 3'b000) begin errors++; $display("FAIL nest_eret2 got=%b exp=000", ISR); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    IR = 3'b100; tick(); int_ack = 1; tick(); int_ack = 0; tick();
    IR = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nopre_req got=%b exp=0", int_req); end
    end
    eret = 1; tick(); eret = 0;
    checks++; if ({ISR, int_req} !== 4'b000_0) begin errors++; $display("FAIL nopre_eret got=%b exp=0000", {ISR, int_req}); end
    tick();
    checks++; if ({int_req, int_id} !== 3'b1_01) begin errors++; $display("FAIL nopre_after got=%b exp=101", {int_req, int_id}); end
  endtask

  task automatic test_withdraw_mask();
    do_reset();
    IR = 3'b001; tick(); ie = 0; tick();
    checks++; if ({int_req, ISR} !== 4'b0_000) begin errors++; $display("FAIL withdraw got=%b exp=0000", {int_req, ISR}); end
    do_reset();
    mask = 3'b110; IR = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL masked_req got=%b exp=0", int_req); end
    end
    mask = 3'b111;
  endtask

  task automatic test_simultaneous();
    do_reset();
    IR = 3'b001; tick(); int_ack = 1; tick(); int_ack = 0; tick();
    IR = 3'b100; tick();
    int_ack = 1; eret = 1; tick(); int_ack = 0; eret = 0;
    checks++; if ({ISR, Clr, ClrInt} !== 7'b100_1_100) begin errors++; $display("FAIL simul got=%b exp=1001100", {ISR, Clr, ClrInt}); end
  endtask

  task automatic test_reset_in_clr();
    do_reset();
    IR = 3'b001; tick(); int_ack = 1; tick(); int_ack = 0;
    checks++; if (Clr !== 1'b1) begin errors++; $display("FAIL rclr_pre got=%b exp=1", Clr); end
    rst = 1'b0; #1;
    checks++; if ({int_req, int_id, Clr, ClrInt, ISR} !== 10'd0 || int_vec !== 32'h3000) begin errors++; $display("FAIL rclr_async got=%b/%h exp=0/3000", {int_req, int_id, Clr, ClrInt, ISR}, int_vec); end
    tick();
    checks++; if (Clr !== 1'b0) begin errors++; $display("FAIL rclr_hold got=%b exp=0", Clr); end
    rst = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) IR = IR | 3'($urandom);
      ie = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 40) == 0) mask = 3'($urandom);
      int_ack = int_req && ($urandom_range(0, 1) == 1);
      eret = ($urandom_range(0, 6) == 0);
      tick();
      checks++; if (int_req !== m_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, int_req, m_req); end
      checks++; if (int_id !== m_id) begin errors++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", n, int_id, m_id); end
      checks++; if (int_vec !== 32'h3000 + 32'(m_id) * 32'h10) begin errors++; $display("FAIL rnd_vec cyc=%0d got=%h", n, int_vec); end
      checks++; if (Clr !== m_clr || ClrInt !== m_clrint) begin errors++; $display("FAIL rnd_clr cyc=%0d got=%b/%b exp=%b/%b", n, Clr, ClrInt, m_clr, m_clrint); end
      checks++; if (ISR !== m_isr) begin errors++; $display("FAIL rnd_isr cyc=%0d got=%b exp=%b", n, ISR, m_isr); end
    end
    int_ack = 0; eret = 0;
  endtask

  initial begin
    m_req = 0; m_clr = 0; m_id = 0; m_isr = 0; m_clrint = 0;
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_no_preempt();
    test_withdraw_mask();
    test_simultaneous();
    test_reset_in_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
